// File: rtl/ne16_tcdm_stream_arbiter.sv
// Round-robin arbiter sharing the NE16 TCDM master port among the streamer requesters,
// with FSM-driven priority mask and an in-order ID FIFO for response routing.
// Optional anti-starvation override: define NE16_TCDM_ARB_STARVATION_EN.
module ne16_tcdm_stream_arbiter #(
    parameter int unsigned NB_REQ       = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 288,
    parameter int unsigned MAX_OUTST    = 4,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [NB_REQ-1:0]        prio_mask_i,
    input  logic [NB_REQ-1:0]        req_i,
    output logic [NB_REQ-1:0]        gnt_o,
    input  logic [NB_REQ-1:0]        wen_i,
    input  logic [NB_REQ*ADDR_W-1:0] add_i,
    input  logic [NB_REQ*DATA_W-1:0] data_i,
    input  logic [NB_REQ*DATA_W/8-1:0] be_i,
    output logic [NB_REQ-1:0]        r_valid_o,
    output logic [DATA_W-1:0]        r_data_o,
    output logic                     tcdm_req_o,
    input  logic                     tcdm_gnt_i,
    output logic [ADDR_W-1:0]        tcdm_add_o,
    output logic                     tcdm_wen_o,
    output logic [DATA_W-1:0]        tcdm_data_o,
    output logic [DATA_W/8-1:0]      tcdm_be_o,
    input  logic                     tcdm_r_valid_i,
    input  logic [DATA_W-1:0]        tcdm_r_data_i,
    output logic                     idle_o,
    output logic                     err_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned ID_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]                 rr_q, rr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [PTR_W-1:0]                wr_q, wr_d, rd_q, rd_d;
    logic [MAX_OUTST-1:0][ID_W-1:0]  fifo_q;
    logic                            err_q, err_d;

    logic [NB_REQ-1:0] masked, cand, starved;
    logic [ID_W-1:0]   win;
    logic              win_vld, full, empty, push, pop;

    assign masked = req_i & prio_mask_i;

    // Starved requesters override the mask; otherwise the mask narrows the set if it hits.
    always_comb begin
        cand = req_i;
        if (|(req_i & starved)) begin
            cand = req_i & starved;
        end else if (|masked) begin
            cand = masked;
        end
    end

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (!win_vld && cand[ID_W'((32'(rr_q) + i) % NB_REQ)]) begin
                win     = ID_W'((32'(rr_q) + i) % NB_REQ);
                win_vld = 1'b1;
            end
        end
    end

    assign full       = (cnt_q == CNT_W'(MAX_OUTST));
    assign empty      = (cnt_q == '0);
    assign tcdm_req_o = win_vld & ~full;
    assign push       = tcdm_req_o & tcdm_gnt_i;
    assign pop        = tcdm_r_valid_i & ~empty;
    assign idle_o     = ~(|req_i) & empty;
    assign err_o      = err_q;
    assign r_data_o   = pop ? tcdm_r_data_i : '0;

    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_data_o = '0;
        tcdm_be_o   = '0;
        gnt_o       = '0;
        r_valid_o   = '0;
        for (int unsigned j = 0; j < NB_REQ; j++) begin
            if (win_vld && win == ID_W'(j)) begin
                tcdm_add_o  = add_i[j*ADDR_W +: ADDR_W];
                tcdm_wen_o  = wen_i[j];
                tcdm_data_o = data_i[j*DATA_W +: DATA_W];
                tcdm_be_o   = be_i[j*BE_W +: BE_W];
                gnt_o[j]    = push;
            end
            r_valid_o[j] = pop && (fifo_q[rd_q] == ID_W'(j));
        end
    end

    // Pointer, FIFO bookkeeping and sticky error; clear dominates everything.
    always_comb begin
        rr_d  = rr_q;
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        err_d = err_q | (tcdm_r_valid_i & empty);
        if (push) begin
            rr_d = (win == ID_W'(NB_REQ - 1)) ? '0 : win + ID_W'(1);
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            rr_d  = '0;
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            fifo_q <= '0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            err_q <= err_d;
            if (push && !clear_i) begin
                fifo_q[wr_q] <= win;
            end
        end
    end

`ifdef NE16_TCDM_ARB_STARVATION_EN
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT) + 1;

    logic [NB_REQ-1:0][SC_W-1:0] wait_q, wait_d;

    // Saturating per-requester wait counters; a full counter marks the requester starved.
    always_comb begin
        wait_d  = '0;
        starved = '0;
        for (int unsigned j = 0; j < NB_REQ; j++) begin
            starved[j] = (wait_q[j] == SC_W'(STARVE_LIMIT));
            if (req_i[j] && !gnt_o[j]) begin
                wait_d[j] = starved[j] ? wait_q[j] : wait_q[j] + SC_W'(1);
            end
        end
        if (clear_i) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_starve_limit;

    assign starved             = '0;
    assign unused_starve_limit = (STARVE_LIMIT == 0);
`endif

endmodule

// File: doc/ne16_tcdm_stream_arbiter.md
Name: ne16_tcdm_stream_arbiter

Overview:
- Shares the single NE16 TCDM master port between the streamer's requesters: weights, infeat, streamin and streamout.
- Round-robin arbitration, with a priority mask driven from the control FSM's state (e.g. streamout favoured in STREAMOUT/STREAMOUT_DONE).
- Tracks outstanding transactions in an ID FIFO and routes in-order responses back to the issuing requester.
- Sits between the per-stream source/sink modules and the HCI core port.

Parameters:
- NB_REQ, 4, number of requesters; index 0=weights, 1=infeat, 2=streamin, 3=streamout.
- ADDR_W, 32, address width.
- DATA_W, 288, data width.
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions (ID FIFO depth, power of 2).
- STARVE_LIMIT, 16, wait-cycle threshold, used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear
- prio_mask_i  in  NB_REQ  high-priority requester set, from the FSM
- req_i  in  NB_REQ  request per requester
- gnt_o  out  NB_REQ  grant per requester
- wen_i  in  NB_REQ  1=read, 0=write
- add_i  in  NB_REQ*ADDR_W  addresses, packed, requester 0 in the LSBs
- data_i  in  NB_REQ*DATA_W  write data, packed
- be_i  in  NB_REQ*DATA_W/8  byte enables, packed
- r_valid_o  out  NB_REQ  response valid, routed to the issuer
- r_data_o  out  DATA_W  response data, broadcast to all requesters
- tcdm_req_o  out  1  master request
- tcdm_gnt_i  in  1  master grant
- tcdm_add_o  out  ADDR_W  master address
- tcdm_wen_o  out  1  master read/write
- tcdm_data_o  out  DATA_W  master write data
- tcdm_be_o  out  DATA_W/8  master byte enables
- tcdm_r_valid_i  in  1  master response valid
- tcdm_r_data_i  in  DATA_W  master response data
- idle_o  out  1  no pending requests and FIFO empty
- err_o  out  1  sticky: response arrived with empty FIFO

Behaviour:
- Reset/clear:
  - RR pointer=0, FIFO empty (count=0), err_o=0.
  - All combinational outputs are 0 when req_i=0.
  - idle_o=1 after reset.
  - clear_i has the same effect as reset, synchronously, and takes precedence over any same-cycle push, pop or pointer update.
- Candidate set C:
  - If (req_i & prio_mask_i) != 0, then C = req_i & prio_mask_i; otherwise C = req_i.
- Winner:
  - First set bit of C scanning upward from the RR pointer, wrapping modulo NB_REQ.
  - Purely combinational from req_i, prio_mask_i, the pointer and the FIFO count: zero-cycle path.
- Blocking:
  - full = (count == MAX_OUTST).
  - When full: tcdm_req_o=0 and gnt_o=0, even if a pop occurs in the same cycle. Deliberately conservative; no bypass.
- Issue:
  - tcdm_req_o = |C & ~full.
  - tcdm_add_o, wen, data and be are muxed from the winner; when there is no winner they are 0.
  - gnt_o[winner] = tcdm_gnt_i & tcdm_req_o; all other gnt_o bits are 0.
- Accept:
  - Condition: tcdm_req_o & tcdm_gnt_i.
  - Push the winner ID into the FIFO; pointer <= (winner+1) mod NB_REQ.
  - The pointer does not move without an accepted handshake, so a requester held off by tcdm_gnt_i=0 keeps its slot.
- Responses:
  - Every accepted transaction, reads and writes alike, expects exactly one tcdm_r_valid_i, in order.
  - On tcdm_r_valid_i with FIFO non-empty: r_valid_o[head]=1, r_data_o=tcdm_r_data_i, pop.
  - On tcdm_r_valid_i with FIFO empty: r_valid_o=0, response dropped, err_o<=1 until clear/reset.
- Push and pop in the same cycle (not full): count unchanged, head advances.
- Count range is 0..MAX_OUTST; log2(MAX_OUTST)+1 bits.
- A requester must hold req_i and its payload stable until granted. The arbiter does not check this.
- Mid-transaction prio_mask_i change: takes effect on the next combinational evaluation; already accepted entries are unaffected.
- idle_o = (req_i==0) & (count==0).

Optional Feature:
- Macro: NE16_TCDM_ARB_STARVATION_EN.
- Defined:
  - Per-requester saturating wait counter, $clog2(STARVE_LIMIT)+1 bits.
  - Increments each cycle req_i[i]=1 & gnt_o[i]=0; resets to 0 on grant, on req_i[i]=0, and on clear/reset.
  - Any requester whose counter reaches STARVE_LIMIT is starved. If any are starved, C = starved set, overriding prio_mask_i; RR among them.
- Undefined: no counters; C follows the mask rule only.

Test Plan:
- Round-robin: all four req_i=1, mask=0, tcdm_gnt_i=1 always, responses 1 cycle later → grants cycle 0,1,2,3,0; r_valid_o follows the same order one cycle behind; err_o=0.
- Priority mask: req_i=4'b1111, mask=4'b1000 → only requester 3 granted while it requests. Drop req_i[3] → RR resumes from the pointer after 3, i.e. requester 0.
- Full FIFO: MAX_OUTST=4, no tcdm_r_valid_i, continuous requests → exactly 4 accepts, then tcdm_req_o=0. One r_valid → the next grant issues on the following cycle, not the same one.
- Stall: tcdm_gnt_i=0 for 5 cycles with req_i=4'b0011 → gnt_o=0, pointer unchanged. Release → requester 0 granted first.
- Error/clear: tcdm_r_valid_i pulse with FIFO empty → err_o=1, r_valid_o=0. clear_i → err_o=0, idle_o=1.
- Starvation (macro defined, STARVE_LIMIT=16): mask=4'b0001, req_i=4'b0011 continuously → requester 1 is granted within 17 cycles, then mask priority returns.
